ct_ifu_ind_btb_ctrl: RTL and testbench
======================================

// Module: ct_ifu_ind_btb_ctrl
// PURPOSE
//  Access controller for the 256x23 indirect-BTB SRAM array; sits directly upstream of the array and drives its CEN/GWEN/A/D/clk_en.
//  Arbitrates prediction reads against buffered BJU update writes, with a starvation guard on writes.
//  Runs the post-reset and software-triggered invalidate sweeps, and returns read data one cycle after the read.
// PARAMETERS
//  IDX_W       8   array index width (256 entries)
//  DATA_W      23  array entry width
//  WBUF_DEPTH  2   update write-buffer entries (FIFO)
//  STARVE_MAX  4   consecutive cycles a pending write may lose to reads before it is forced
// PORTS
//  forever_cpuclk   in   1       free-running cpu clock; the only clock
//  cpurst           in   1       synchronous, active-high reset
//  cp0_ifu_ind_btb_en in 1       0: reads are not issued; rd_vld stays 0; writes and sweeps still run
//  ifu_ind_btb_inv  in   1       1-cycle pulse: invalidate all entries
//  rd_req           in   1       prediction read request this cycle
//  rd_index         in   IDX_W   read index
//  rd_vld           out  1       read data valid (cycle after the read is issued)
//  rd_data          out  DATA_W  read data
//  upd_vld          in   1       update write request
//  upd_index        in   IDX_W   update index
//  upd_data         in   DATA_W  update data
//  upd_rdy          out  1       write buffer can accept (= !full && state==IDLE)
//  inv_busy         out  1       1 in INIT/INV states
//  ind_btb_cen_b    out  1       array chip enable, active-low
//  ind_btb_wen_b    out  1       array write enable, active-low
//  ind_btb_index    out  IDX_W   array address
//  ind_btb_data_in  out  DATA_W  array write data
//  ind_btb_clk_en   out  1       array gated-clock local enable; = ~ind_btb_cen_b
//  ind_btb_dout     in   DATA_W  array read data, valid 1 cycle after a read
// BEHAVIOUR
//  While cpurst=1: cen_b=1, wen_b=1, clk_en=0, index=0, data_in=0, rd_vld=0, upd_rdy=0, inv_busy=1, wbuf empty, starve cnt=0.
//   Next state is INIT with sweep cnt=0. Reset mid-sweep restarts the sweep at index 0.
//  FSM INIT/INV: each cycle write 0 to index=sweep cnt (cen_b=0, wen_b=0), then cnt++.
//   At cnt==255 the write happens and the FSM moves to IDLE; a sweep takes 256 cycles.
//   No reads, rd_vld=0, upd_rdy=0 during a sweep.
//  IDLE + ifu_ind_btb_inv=1: go to INV (cnt=0), discard wbuf contents. Any read requested in that cycle is not issued.
//   inv pulses during INIT/INV are ignored.
//  IDLE arbitration each cycle, in priority order:
//   1. wbuf non-empty && starve==STARVE_MAX: write head entry, pop.
//   2. rd_req && cp0_ifu_ind_btb_en: read rd_index (cen_b=0, wen_b=1).
//   3. wbuf non-empty: write head entry, pop.
//   4. else idle (cen_b=1).
//  starve: +1 when wbuf non-empty and no write is issued; cleared on any write; saturates at STARVE_MAX.
//  A dropped read (rule 1) gets no response: rd_vld=0 next cycle. Requestor treats this as a miss; there is no retry.
//  rd_vld is a registered copy of the read-issue condition. rd_data = ind_btb_dout when rd_vld=1; otherwise don't-care.
//  wbuf: FIFO, push on upd_vld&&upd_rdy. A simultaneous push and pop is legal.
//   upd_rdy depends only on count (full => 0 even if a pop occurs this cycle).
//  The same index may appear twice in wbuf; writes drain in order, so the younger entry wins.
// CONFIGURATION
//  IND_BTB_WBUF_BYPASS_EN defined: in the cycle a read is issued, rd_index is compared to all valid wbuf entries, excluding one being popped that cycle.
//   On a match, the youngest matching entry's data is registered and driven on rd_data the next cycle instead of ind_btb_dout. The SRAM read is still issued.
//  Undefined: no compare; rd_data always = ind_btb_dout, so stale data is possible until the write drains.
// TESTING
//  Reset release -> inv_busy=1 for 256 cycles; indices 0..255 written with 0 (wen_b=0); then IDLE, upd_rdy=1.
//  upd(idx 0x12, data 0x5A5A5) with no reads -> write at 0x12 next cycle; later rd_req 0x12 -> rd_vld=1, rd_data=0x5A5A5 one cycle after the read.
//  1 update pending + rd_req held high -> 4 reads issued, 5th cycle forces the write; rd_vld=0 in the cycle after that drop.
//  Push 2 updates while reads are continuous -> upd_rdy=0 when full; a 3rd upd_vld is not accepted until a pop occurs.
//  ifu_ind_btb_inv with 2 buffered updates -> wbuf discarded, 256-cycle sweep, then a read of either index returns 0.
//  BYPASS_EN: upd idx 0x40 data 0x1 buffered, rd 0x40 issued before drain -> rd_data=0x1; macro undefined -> rd_data=old array value.

Source files
------------

// File: rtl/ct_ifu_ind_btb_ctrl_if.sv
// Signal bundle between the indirect-BTB access controller, its requestors and the 256x23 SRAM array.
// The slave modport is the controller; the master modport is the requestor/array side.
interface ct_ifu_ind_btb_ctrl_if #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 23
);
    logic              cp0_ifu_ind_btb_en;
    logic              ifu_ind_btb_inv;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_index;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic              upd_vld;
    logic [IDX_W-1:0]  upd_index;
    logic [DATA_W-1:0] upd_data;
    logic              upd_rdy;
    logic              inv_busy;
    logic              ind_btb_cen_b;
    logic              ind_btb_wen_b;
    logic [IDX_W-1:0]  ind_btb_index;
    logic [DATA_W-1:0] ind_btb_data_in;
    logic              ind_btb_clk_en;
    logic [DATA_W-1:0] ind_btb_dout;

    modport slave (
        input  cp0_ifu_ind_btb_en, ifu_ind_btb_inv,
        input  rd_req, rd_index,
        output rd_vld, rd_data,
        input  upd_vld, upd_index, upd_data,
        output upd_rdy, inv_busy,
        output ind_btb_cen_b, ind_btb_wen_b, ind_btb_index, ind_btb_data_in, ind_btb_clk_en,
        input  ind_btb_dout
    );

    modport master (
        output cp0_ifu_ind_btb_en, ifu_ind_btb_inv,
        output rd_req, rd_index,
        input  rd_vld, rd_data,
        output upd_vld, upd_index, upd_data,
        input  upd_rdy, inv_busy,
        input  ind_btb_cen_b, ind_btb_wen_b, ind_btb_index, ind_btb_data_in, ind_btb_clk_en,
        output ind_btb_dout
    );
endinterface

// File: rtl/ct_ifu_ind_btb_ctrl.sv
// Indirect-BTB SRAM access controller: read/update arbitration with write starvation guard, invalidate sweeps.
// Optional macro IND_BTB_WBUF_BYPASS_EN forwards buffered update data to reads of the same index.
//
// state | meaning
// INIT  | post-reset sweep, writes 0 to every entry
// IDLE  | arbitrate prediction reads against buffered updates
// INV   | software-triggered sweep, writes 0 to every entry
module ct_ifu_ind_btb_ctrl #(
    parameter int IDX_W      = 8,
    parameter int DATA_W     = 23,
    parameter int WBUF_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    ct_ifu_ind_btb_ctrl_if.slave  bif
);
    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_INV  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_cnt_q, sweep_cnt_d;
    logic [IDX_W-1:0]  wbuf_idx_q  [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              rd_vld_q;

    logic              wbuf_empty;
    logic              wbuf_full;
    logic              starved;
    logic              upd_rdy_c;
    logic              push;
    logic              pop;
    logic              flush;
    logic              rd_issue;
    logic              cen_b_c;
    logic              wen_b_c;
    logic [IDX_W-1:0]  index_c;
    logic [DATA_W-1:0] data_c;
    logic              cen_b;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wbuf_empty = (count_q == '0);
    assign wbuf_full  = (count_q == CNT_W'(WBUF_DEPTH));
    assign starved    = (starve_q == STV_W'(STARVE_MAX));
    // Readiness looks only at the registered count so it never depends on this cycle's pop.
    assign upd_rdy_c  = !cpurst && (state_q == ST_IDLE) && !wbuf_full;
    assign push       = bif.upd_vld && upd_rdy_c && !flush;

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        cen_b_c     = 1'b1;
        wen_b_c     = 1'b1;
        index_c     = '0;
        data_c      = '0;
        pop         = 1'b0;
        flush       = 1'b0;
        rd_issue    = 1'b0;
        case (state_q)
            ST_INIT, ST_INV: begin
                cen_b_c     = 1'b0;
                wen_b_c     = 1'b0;
                index_c     = sweep_cnt_q;
                sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
                if (sweep_cnt_q == SWEEP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bif.ifu_ind_btb_inv) begin
                    flush       = 1'b1;
                    state_d     = ST_INV;
                    sweep_cnt_d = '0;
                end else if (!wbuf_empty && starved) begin
                    cen_b_c = 1'b0;
                    wen_b_c = 1'b0;
                    index_c = wbuf_idx_q[rd_ptr_q];
                    data_c  = wbuf_data_q[rd_ptr_q];
                    pop     = 1'b1;
                end else if (bif.rd_req && bif.cp0_ifu_ind_btb_en) begin
                    cen_b_c  = 1'b0;
                    index_c  = bif.rd_index;
                    rd_issue = 1'b1;
                end else if (!wbuf_empty) begin
                    cen_b_c = 1'b0;
                    wen_b_c = 1'b0;
                    index_c = wbuf_idx_q[rd_ptr_q];
                    data_c  = wbuf_data_q[rd_ptr_q];
                    pop     = 1'b1;
                end
            end
            default: begin
                state_d     = ST_INIT;
                sweep_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        // Sweep writes and discards both count as the pending write being serviced.
        if ((state_q != ST_IDLE) || pop || flush) begin
            starve_d = '0;
        end else if (!wbuf_empty && !starved) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            rd_vld_q    <= rd_issue;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (push) begin
            wbuf_idx_q[wr_ptr_q]  <= bif.upd_index;
            wbuf_data_q[wr_ptr_q] <= bif.upd_data;
        end
    end

`ifdef IND_BTB_WBUF_BYPASS_EN
    logic              byp_hit_c, byp_hit_q;
    logic [DATA_W-1:0] byp_data_c, byp_data_q;
    logic [PTR_W-1:0]  byp_slot;

    // Walk oldest to youngest so the youngest matching entry is the one kept.
    always_comb begin
        byp_hit_c  = 1'b0;
        byp_data_c = '0;
        byp_slot   = rd_ptr_q;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && !((i == 0) && pop)) begin
                if (wbuf_idx_q[byp_slot] == bif.rd_index) begin
                    byp_hit_c  = 1'b1;
                    byp_data_c = wbuf_data_q[byp_slot];
                end
            end
            byp_slot = ptr_inc(byp_slot);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= rd_issue && byp_hit_c;
            byp_data_q <= byp_data_c;
        end
    end

    assign bif.rd_data = byp_hit_q ? byp_data_q : bif.ind_btb_dout;
`else
    assign bif.rd_data = bif.ind_btb_dout;
`endif

    assign cen_b               = cpurst | cen_b_c;
    assign bif.ind_btb_cen_b   = cen_b;
    assign bif.ind_btb_wen_b   = cpurst | wen_b_c;
    assign bif.ind_btb_index   = cpurst ? '0 : index_c;
    assign bif.ind_btb_data_in = cpurst ? '0 : data_c;
    assign bif.ind_btb_clk_en  = ~cen_b;
    assign bif.rd_vld          = rd_vld_q;
    assign bif.upd_rdy         = upd_rdy_c;
    assign bif.inv_busy        = cpurst | (state_q != ST_IDLE);
endmodule

// File: tb/tb_ct_ifu_ind_btb_ctrl.sv
// Self-checking bench for ct_ifu_ind_btb_ctrl with a behavioural 256x23 SRAM and a read-data scoreboard.
module tb_ct_ifu_ind_btb_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [22:0] exp_q[$];
    logic [22:0] exp_v;
    logic [22:0] sram [256];

`ifdef IND_BTB_WBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    ct_ifu_ind_btb_ctrl_if #(.IDX_W(8), .DATA_W(23)) bif ();

    ct_ifu_ind_btb_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bif            (bif)
    );

    logic [9:0]  acc_rd;
    logic [32:0] acc_wr;
    assign acc_rd = {bif.ind_btb_cen_b, bif.ind_btb_wen_b, bif.ind_btb_index};
    assign acc_wr = {bif.ind_btb_cen_b, bif.ind_btb_wen_b, bif.ind_btb_index, bif.ind_btb_data_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model; filled with junk during reset so the sweep has something to clear.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= 23'h7FFFF ^ 23'(i);
        end
        if (bif.ind_btb_cen_b === 1'b0) begin
            if (bif.ind_btb_wen_b === 1'b0) sram[bif.ind_btb_index] <= bif.ind_btb_data_in;
            else bif.ind_btb_dout <= sram[bif.ind_btb_index];
        end
    end

    // Scoreboard: every response is matched against the oldest expected read.
    always @(posedge clk) begin
        #3;
        if (!rst && bif.rd_vld === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_unexpected: rd_vld=1 rd_data=%h, required no response", bif.rd_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (bif.rd_data !== exp_v) begin
                    n_errors++;
                    $display("FAIL rd_data: got %h, required %h", bif.rd_data, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            #1;
            n_checks++;
            if (acc_wr !== {2'b11, 8'h00, 23'h0} || bif.ind_btb_clk_en !== 1'b0 || bif.rd_vld !== 1'b0 ||
                bif.upd_rdy !== 1'b0 || bif.inv_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_outputs: cen/wen/idx/din=%h clk_en=%b rd_vld=%b upd_rdy=%b inv_busy=%b, required 1/1/0/0 0 0 0 1",
                         acc_wr, bif.ind_btb_clk_en, bif.rd_vld, bif.upd_rdy, bif.inv_busy);
            end
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) tick();
            #1;
            n_checks++;
            if (acc_wr !== {2'b00, 8'(i), 23'h0}) begin
                n_errors++;
                $display("FAIL partial_sweep: access=%h, required write 0 at %0d", acc_wr, i);
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) tick();
            #1;
            n_checks++;
            if (acc_wr !== {2'b00, 8'(i), 23'h0} || bif.ind_btb_clk_en !== 1'b1 || bif.inv_busy !== 1'b1 ||
                bif.upd_rdy !== 1'b0 || bif.rd_vld !== 1'b0) begin
                n_errors++;
                $display("FAIL init_sweep: step %0d access=%h clk_en=%b inv_busy=%b upd_rdy=%b rd_vld=%b, required write 0 at %0d, 1 1 0 0",
                         i, acc_wr, bif.ind_btb_clk_en, bif.inv_busy, bif.upd_rdy, bif.rd_vld, i);
            end
        end
        tick();
        #1;
        n_checks++;
        if (bif.inv_busy !== 1'b0 || bif.upd_rdy !== 1'b1 || bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL init_done: inv_busy=%b upd_rdy=%b cen_b=%b, required 0 1 1", bif.inv_busy, bif.upd_rdy, bif.ind_btb_cen_b);
        end
    endtask

    task automatic test_write_read();
        tick();
        bif.upd_vld = 1'b1; bif.upd_index = 8'h12; bif.upd_data = 23'h5A5A5;
        #1;
        n_checks++;
        if (bif.upd_rdy !== 1'b1 || bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_accept: upd_rdy=%b cen_b=%b, required 1 1", bif.upd_rdy, bif.ind_btb_cen_b);
        end
        tick();
        bif.upd_vld = 1'b0;
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h12, 23'h5A5A5} || bif.ind_btb_clk_en !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_drain: access=%h clk_en=%b, required %h 1", acc_wr, bif.ind_btb_clk_en, {2'b00, 8'h12, 23'h5A5A5});
        end
        tick();
        #1;
        n_checks++;
        if (bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_idle: cen_b=%b, required 1", bif.ind_btb_cen_b);
        end
        tick();
        bif.rd_req = 1'b1; bif.rd_index = 8'h12; exp_q.push_back(23'h5A5A5);
        #1;
        n_checks++;
        if (acc_rd !== {2'b01, 8'h12}) begin
            n_errors++;
            $display("FAIL rd_issue: access=%h, required %h", acc_rd, {2'b01, 8'h12});
        end
        tick();
        bif.rd_index = 8'h13; exp_q.push_back(23'h0);
        #1;
        n_checks++;
        if (bif.rd_vld !== 1'b1 || acc_rd !== {2'b01, 8'h13}) begin
            n_errors++;
            $display("FAIL rd_b2b: rd_vld=%b access=%h, required 1 %h", bif.rd_vld, acc_rd, {2'b01, 8'h13});
        end
        tick();
        bif.rd_req = 1'b0;
        tick();
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL wr_rd_drained: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_starve();
        tick();
        bif.rd_req = 1'b1; bif.rd_index = 8'h12;
        bif.upd_vld = 1'b1; bif.upd_index = 8'h20; bif.upd_data = 23'h00123;
        exp_q.push_back(23'h5A5A5);
        #1;
        n_checks++;
        if (bif.upd_rdy !== 1'b1 || acc_rd !== {2'b01, 8'h12}) begin
            n_errors++;
            $display("FAIL starve_first: upd_rdy=%b access=%h, required 1 %h", bif.upd_rdy, acc_rd, {2'b01, 8'h12});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            bif.upd_vld = 1'b0;
            exp_q.push_back(23'h5A5A5);
            #1;
            n_checks++;
            if (acc_rd !== {2'b01, 8'h12}) begin
                n_errors++;
                $display("FAIL starve_read%0d: access=%h, required read 0x12", k, acc_rd);
            end
        end
        tick();
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h20, 23'h00123}) begin
            n_errors++;
            $display("FAIL starve_force: access=%h, required %h", acc_wr, {2'b00, 8'h20, 23'h00123});
        end
        tick();
        bif.rd_req = 1'b0;
        #1;
        n_checks++;
        if (bif.rd_vld !== 1'b0 || bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL starve_drop: rd_vld=%b cen_b=%b, required 0 1", bif.rd_vld, bif.ind_btb_cen_b);
        end
        tick();
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL starve_drained: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        tick();
        bif.rd_req = 1'b1; bif.rd_index = 8'h12;
        bif.upd_vld = 1'b1; bif.upd_index = 8'h30; bif.upd_data = 23'h30030;
        exp_q.push_back(23'h5A5A5);
        #1;
        n_checks++;
        if (bif.upd_rdy !== 1'b1 || acc_rd !== {2'b01, 8'h12}) begin
            n_errors++;
            $display("FAIL full_push0: upd_rdy=%b access=%h, required 1 read", bif.upd_rdy, acc_rd);
        end
        tick();
        bif.upd_index = 8'h31; bif.upd_data = 23'h31031;
        exp_q.push_back(23'h5A5A5);
        #1;
        n_checks++;
        if (bif.upd_rdy !== 1'b1 || acc_rd !== {2'b01, 8'h12}) begin
            n_errors++;
            $display("FAIL full_push1: upd_rdy=%b access=%h, required 1 read", bif.upd_rdy, acc_rd);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            bif.upd_index = 8'h32; bif.upd_data = 23'h32032;
            exp_q.push_back(23'h5A5A5);
            #1;
            n_checks++;
            if (bif.upd_rdy !== 1'b0 || acc_rd !== {2'b01, 8'h12}) begin
                n_errors++;
                $display("FAIL full_block%0d: upd_rdy=%b access=%h, required 0 read", k, bif.upd_rdy, acc_rd);
            end
        end
        tick();
        #1;
        n_checks++;
        if (bif.upd_rdy !== 1'b0 || acc_wr !== {2'b00, 8'h30, 23'h30030}) begin
            n_errors++;
            $display("FAIL full_force: upd_rdy=%b access=%h, required 0 write 0x30", bif.upd_rdy, acc_wr);
        end
        tick();
        exp_q.push_back(23'h5A5A5);
        #1;
        n_checks++;
        if (bif.rd_vld !== 1'b0 || bif.upd_rdy !== 1'b1 || acc_rd !== {2'b01, 8'h12}) begin
            n_errors++;
            $display("FAIL full_reopen: rd_vld=%b upd_rdy=%b access=%h, required 0 1 read", bif.rd_vld, bif.upd_rdy, acc_rd);
        end
        tick();
        bif.upd_vld = 1'b0; bif.rd_req = 1'b0;
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h31, 23'h31031}) begin
            n_errors++;
            $display("FAIL full_drain1: access=%h, required write 0x31", acc_wr);
        end
        tick();
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h32, 23'h32032}) begin
            n_errors++;
            $display("FAIL full_drain2: access=%h, required write 0x32", acc_wr);
        end
        tick();
        #1;
        n_checks++;
        if (bif.ind_btb_cen_b !== 1'b1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL full_done: cen_b=%b outstanding=%0d, required 1 0", bif.ind_btb_cen_b, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  idxs [5];
        logic [22:0] vals [5];
        idxs[0] = 8'h12; vals[0] = 23'h5A5A5;
        idxs[1] = 8'h20; vals[1] = 23'h00123;
        idxs[2] = 8'h30; vals[2] = 23'h30030;
        idxs[3] = 8'h31; vals[3] = 23'h31031;
        idxs[4] = 8'h32; vals[4] = 23'h32032;
        for (int k = 0; k < 5; k++) begin
            tick();
            bif.rd_req = 1'b1; bif.rd_index = idxs[k];
            exp_q.push_back(vals[k]);
            #1;
            n_checks++;
            if (acc_rd !== {2'b01, idxs[k]}) begin
                n_errors++;
                $display("FAIL b2b_issue%0d: access=%h, required read %h", k, acc_rd, idxs[k]);
            end
        end
        tick();
        bif.rd_req = 1'b0;
        tick();
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_drained: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_rd_disable();
        tick();
        bif.cp0_ifu_ind_btb_en = 1'b0; bif.rd_req = 1'b1; bif.rd_index = 8'h12;
        bif.upd_vld = 1'b1; bif.upd_index = 8'h21; bif.upd_data = 23'h0BEEF;
        #1;
        n_checks++;
        if (bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL dis_no_read: cen_b=%b, required 1", bif.ind_btb_cen_b);
        end
        tick();
        bif.upd_vld = 1'b0;
        #1;
        n_checks++;
        if (bif.rd_vld !== 1'b0 || acc_wr !== {2'b00, 8'h21, 23'h0BEEF}) begin
            n_errors++;
            $display("FAIL dis_write: rd_vld=%b access=%h, required 0 write 0x21", bif.rd_vld, acc_wr);
        end
        tick();
        bif.cp0_ifu_ind_btb_en = 1'b1; bif.rd_req = 1'b0;
        #1;
        n_checks++;
        if (bif.rd_vld !== 1'b0 || bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL dis_quiet: rd_vld=%b cen_b=%b, required 0 1", bif.rd_vld, bif.ind_btb_cen_b);
        end
    endtask

    task automatic test_inv();
        tick();
        bif.rd_req = 1'b1; bif.rd_index = 8'h12;
        bif.upd_vld = 1'b1; bif.upd_index = 8'h50; bif.upd_data = 23'h00077;
        exp_q.push_back(23'h5A5A5);
        tick();
        bif.upd_index = 8'h51; bif.upd_data = 23'h00066;
        exp_q.push_back(23'h5A5A5);
        tick();
        bif.upd_vld = 1'b0; bif.ifu_ind_btb_inv = 1'b1;
        #1;
        n_checks++;
        if (bif.ind_btb_cen_b !== 1'b1 || bif.upd_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL inv_entry: cen_b=%b upd_rdy=%b, required 1 0", bif.ind_btb_cen_b, bif.upd_rdy);
        end
        tick();
        bif.ifu_ind_btb_inv = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i != 0) begin
                tick();
                bif.ifu_ind_btb_inv = (i == 100);
            end
            #1;
            n_checks++;
            if (acc_wr !== {2'b00, 8'(i), 23'h0} || bif.inv_busy !== 1'b1 || bif.upd_rdy !== 1'b0 || bif.rd_vld !== 1'b0) begin
                n_errors++;
                $display("FAIL inv_sweep: step %0d access=%h inv_busy=%b upd_rdy=%b rd_vld=%b, required write 0 at %0d, 1 0 0",
                         i, acc_wr, bif.inv_busy, bif.upd_rdy, bif.rd_vld, i);
            end
        end
        tick();
        bif.ifu_ind_btb_inv = 1'b0; bif.rd_req = 1'b0;
        #1;
        n_checks++;
        if (bif.inv_busy !== 1'b0 || bif.upd_rdy !== 1'b1 || bif.ind_btb_cen_b !== 1'b1) begin
            n_errors++;
            $display("FAIL inv_done: inv_busy=%b upd_rdy=%b cen_b=%b, required 0 1 1 (buffer discarded)",
                     bif.inv_busy, bif.upd_rdy, bif.ind_btb_cen_b);
        end
        tick();
        bif.rd_req = 1'b1; bif.rd_index = 8'h50; exp_q.push_back(23'h0);
        tick();
        bif.rd_index = 8'h51; exp_q.push_back(23'h0);
        tick();
        bif.rd_index = 8'h12; exp_q.push_back(23'h0);
        tick();
        bif.rd_req = 1'b0;
        tick();
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL inv_drained: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_bypass();
        tick();
        bif.upd_vld = 1'b1; bif.upd_index = 8'h40; bif.upd_data = 23'h7;
        tick();
        bif.upd_vld = 1'b0;
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h40, 23'h7}) begin
            n_errors++;
            $display("FAIL byp_seed: access=%h, required write 0x40 data 7", acc_wr);
        end
        tick();
        bif.upd_vld = 1'b1; bif.upd_data = 23'h1;
        tick();
        bif.upd_vld = 1'b0; bif.rd_req = 1'b1; bif.rd_index = 8'h40;
        exp_q.push_back(BYP ? 23'h1 : 23'h7);
        #1;
        n_checks++;
        if (acc_rd !== {2'b01, 8'h40}) begin
            n_errors++;
            $display("FAIL byp_issue: access=%h, required read 0x40", acc_rd);
        end
        tick();
        bif.rd_req = 1'b0;
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h40, 23'h1}) begin
            n_errors++;
            $display("FAIL byp_drain: access=%h, required write 0x40 data 1", acc_wr);
        end
        tick();
        bif.rd_req = 1'b1; bif.rd_index = 8'h40; exp_q.push_back(23'h1);
        // Two buffered writes to one index: the younger one must win.
        tick();
        bif.rd_index = 8'h12; exp_q.push_back(23'h0);
        bif.upd_vld = 1'b1; bif.upd_index = 8'h41; bif.upd_data = 23'h2;
        tick();
        exp_q.push_back(23'h0);
        bif.upd_data = 23'h3;
        tick();
        bif.upd_vld = 1'b0; bif.rd_index = 8'h41;
        exp_q.push_back(BYP ? 23'h3 : 23'h0);
        #1;
        n_checks++;
        if (acc_rd !== {2'b01, 8'h41}) begin
            n_errors++;
            $display("FAIL byp_young_issue: access=%h, required read 0x41", acc_rd);
        end
        tick();
        bif.rd_req = 1'b0;
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h41, 23'h2}) begin
            n_errors++;
            $display("FAIL byp_order0: access=%h, required write 0x41 data 2", acc_wr);
        end
        tick();
        #1;
        n_checks++;
        if (acc_wr !== {2'b00, 8'h41, 23'h3}) begin
            n_errors++;
            $display("FAIL byp_order1: access=%h, required write 0x41 data 3", acc_wr);
        end
        tick();
        bif.rd_req = 1'b1; exp_q.push_back(23'h3);
        tick();
        bif.rd_req = 1'b0;
        tick();
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL byp_drained: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bif.cp0_ifu_ind_btb_en = 1'b1;
        bif.ifu_ind_btb_inv    = 1'b0;
        bif.rd_req             = 1'b0;
        bif.rd_index           = '0;
        bif.upd_vld            = 1'b0;
        bif.upd_index          = '0;
        bif.upd_data           = '0;
        test_reset();
        test_write_read();
        test_starve();
        test_full();
        test_back_to_back();
        test_rd_disable();
        test_inv();
        test_bypass();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
